rib_store_buf: RTL and testbench

- Posted-write buffer between the core's data-side bus master port (addr/data/req/we plus hold) and the RIB master 0 slot.
- RAM stores are queued and the core continues without waiting; stores drain to the bus in the background.
- Loads that hit a queued word are forwarded from the buffer; loads that miss bypass the queue.
- IO-region accesses and fences are strictly ordered behind all queued stores.

---
 rtl/rib_store_buf_pkg.sv | 35 +++
 rtl/rib_store_buf_fifo.sv | 81 ++++++++
 rtl/rib_store_buf.sv | 136 +++++++++++++
 tb/tb_rib_store_buf.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_store_buf_pkg.sv
// Shared definitions for the RIB posted-write store buffer.
//   RAM_TAG_DEF  : default addr[31:28] tag marking bufferable RAM
//   ENTRY_W      : width of one queued store {addr[31:2], data}
//   sb_entry_t   : packed view of a queued store
//   sb_sel_t     : per-cycle arbitration outcome
package rib_store_buf_pkg;

  localparam logic [3:0]  RAM_TAG_DEF = 4'h1;
  localparam int unsigned ADDR_W      = 30;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ENTRY_W     = ADDR_W + DATA_W;

  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable   = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [2:0] {
    SEL_WAIT,   // IO or fence behind queued stores: hold and drain
    SEL_IO,     // IO access with empty queue: direct pass-through
    SEL_ENQ,    // RAM store with room: post it
    SEL_FULL,   // RAM store with full queue: hold and drain
    SEL_HIT,    // RAM load forwarded from the queue
    SEL_MISS,   // RAM load not in the queue: bus read
    SEL_IDLE    // no request: background drain
  } sb_sel_t;

  function automatic logic is_ram(input logic [31:0] addr, input logic [3:0] tag);
    return addr[31:28] == tag;
  endfunction

endpackage

// File: rtl/rib_store_buf_fifo.sv
// sb_fifo: circular store queue with a parallel address match port.
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_entry  : enqueue at the tail
//   pop               : dequeue the head
//   head              : oldest entry
//   count             : number of queued entries
//   match_addr        : word address to look up
//   hit, hit_data     : youngest valid entry matching match_addr
module sb_fifo
  import rib_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head,
  output logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      idx;
  sb_entry_t          probe;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = sb_entry_t'(mem[rd_ptr]);

  // Scan oldest to youngest from the head; the last hit wins, so the
  // youngest matching store is forwarded.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    probe    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx   = rd_ptr + AW'(i);
      probe = sb_entry_t'(mem[idx]);
      if (valid[idx] && probe.addr == match_addr) begin
        hit      = 1'b1;
        hit_data = probe.data;
      end
    end
  end

endmodule

// File: rtl/rib_store_buf.sv
// rib_store_buf: posted-write buffer between the core data port and RIB master 0.
//   clk, rst               : clock, asynchronous active-low reset
//   core_addr_i/data_i     : core access address / store data
//   core_req_i, core_we_i  : core request, 1 = store
//   core_flush_i           : fence, hold until the queue is empty
//   core_data_o            : load data to the core
//   core_hold_o            : core stall
//   bus_addr_o/data_o      : RIB address / write data
//   bus_req_o, bus_we_o    : RIB request / write enable
//   bus_data_i, bus_ready_i: RIB read data / access accepted
//   empty_o                : queue empty
module rib_store_buf
  import rib_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  RAM_TAG = RAM_TAG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic        core_flush_i,
  output logic [31:0] core_data_o,
  output logic        core_hold_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ready_i,
  output logic        empty_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  sb_entry_t         head;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              push;
  logic              pop;
  logic              drain;
  logic              io_req;
  logic              nonempty;
  logic              full;
  sb_sel_t           sel;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{addr: core_addr_i[31:2], data: core_data_i}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .match_addr (core_addr_i[31:2]),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  assign io_req   = core_req_i && !is_ram(core_addr_i, RAM_TAG);
  assign nonempty = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign empty_o  = !nonempty;

  always_comb begin
    if ((io_req || core_flush_i) && nonempty) sel = SEL_WAIT;
    else if (io_req)                          sel = SEL_IO;
    else if (core_req_i && core_we_i)         sel = full ? SEL_FULL : SEL_ENQ;
    else if (core_req_i)                      sel = hit ? SEL_HIT : SEL_MISS;
    else                                      sel = SEL_IDLE;
  end

  // Full-queue store acceptance deliberately ignores bus_ready_i, so a pop
  // in the same cycle only frees the slot for the following cycle.
  always_comb begin
    core_data_o = '0;
    core_hold_o = 1'b0;
    bus_addr_o  = '0;
    bus_data_o  = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    drain       = 1'b0;
    case (sel)
      SEL_WAIT, SEL_FULL: begin
        core_hold_o = 1'b1;
        drain       = 1'b1;
      end
      SEL_IO: begin
        bus_addr_o  = core_addr_i;
        bus_data_o  = core_data_i;
        bus_we_o    = core_we_i;
        bus_req_o   = 1'b1;
        core_data_o = bus_data_i;
        core_hold_o = !bus_ready_i;
      end
      SEL_ENQ: begin
        push  = 1'b1;
        drain = 1'b1;
      end
      SEL_HIT: begin
        core_data_o = hit_data;
        drain       = 1'b1;
      end
      SEL_MISS: begin
        bus_addr_o  = core_addr_i;
        bus_req_o   = 1'b1;
        core_data_o = bus_data_i;
        core_hold_o = !bus_ready_i;
      end
      default: drain = 1'b1;
    endcase
    if (drain && nonempty) begin
      bus_addr_o = {head.addr, 2'b00};
      bus_data_o = head.data;
      bus_we_o   = WriteEnable;
      bus_req_o  = 1'b1;
      pop        = bus_ready_i;
    end
    if (rst == RstEnable) begin
      core_data_o = '0;
      core_hold_o = 1'b0;
      bus_addr_o  = '0;
      bus_data_o  = '0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
    end
  end

endmodule

// File: tb/tb_rib_store_buf.sv
// Self-checking bench for rib_store_buf: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rib_store_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr_i, core_data_i, core_data_o;
  logic        core_req_i, core_we_i, core_flush_i, core_hold_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
  logic        bus_req_o, bus_we_o, bus_ready_i, empty_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rib_store_buf #(.DEPTH(4), .RAM_TAG(4'h1)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_addr_i  (core_addr_i),
    .core_data_i  (core_data_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_flush_i (core_flush_i),
    .core_data_o  (core_data_o),
    .core_hold_o  (core_hold_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_data_i   (bus_data_i),
    .bus_ready_i  (bus_ready_i),
    .empty_o      (empty_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  logic        m_push, m_pop;
  logic        e_hold, e_req, e_we, e_chk_cd, m_drain, m_ram, m_io, m_hit;
  logic [31:0] e_cd, e_ba, e_bd;
  int          m_n;

  always @(negedge clk) begin
    m_push = 1'b0;
    m_pop  = 1'b0;
    if (!rst) begin
      q.delete();
      chk("rst_core_data", core_data_o, 32'h0);
      chk("rst_hold", core_hold_o, 32'h0);
      chk("rst_bus_addr", bus_addr_o, 32'h0);
      chk("rst_bus_data", bus_data_o, 32'h0);
      chk("rst_bus_req", bus_req_o, 32'h0);
      chk("rst_bus_we", bus_we_o, 32'h0);
      chk("rst_empty", empty_o, 32'h1);
    end else begin
      m_n      = q.size();
      m_ram    = (core_addr_i[31:28] == 4'h1);
      m_io     = core_req_i && !m_ram;
      e_hold   = 1'b0;
      e_req    = 1'b0;
      e_we     = 1'b0;
      e_chk_cd = 1'b0;
      m_drain  = 1'b0;
      e_cd     = '0;
      e_ba     = '0;
      e_bd     = '0;
      if ((m_io || core_flush_i) && m_n > 0) begin
        e_hold  = 1'b1;
        m_drain = 1'b1;
      end else if (m_io) begin
        e_req    = 1'b1;
        e_we     = core_we_i;
        e_ba     = core_addr_i;
        e_bd     = core_data_i;
        e_chk_cd = !core_we_i;
        e_cd     = bus_data_i;
        e_hold   = !bus_ready_i;
      end else if (core_req_i && core_we_i) begin
        if (m_n < 4) m_push = 1'b1;
        else         e_hold = 1'b1;
        m_drain = 1'b1;
      end else if (core_req_i) begin
        m_hit = 1'b0;
        for (int i = 0; i < m_n; i++)
          if (q[i].a == core_addr_i[31:2]) begin
            m_hit = 1'b1;
            e_cd  = q[i].d;
          end
        e_chk_cd = 1'b1;
        if (m_hit) m_drain = 1'b1;
        else begin
          e_req  = 1'b1;
          e_ba   = core_addr_i;
          e_cd   = bus_data_i;
          e_hold = !bus_ready_i;
        end
      end else begin
        m_drain = 1'b1;
      end
      if (m_drain && m_n > 0) begin
        e_req = 1'b1;
        e_we  = 1'b1;
        e_ba  = {q[0].a, 2'b00};
        e_bd  = q[0].d;
        m_pop = bus_ready_i;
      end
      chk("m_hold", core_hold_o, e_hold);
      chk("m_bus_req", bus_req_o, e_req);
      chk("m_empty", empty_o, (m_n == 0));
      if (e_req) begin
        chk("m_bus_we", bus_we_o, e_we);
        chk("m_bus_addr", bus_addr_o, e_ba);
        if (e_we) chk("m_bus_data", bus_data_o, e_bd);
      end
      if (e_chk_cd) chk("m_core_data", core_data_o, e_cd);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{core_addr_i[31:2], core_data_i});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic fl, input logic rdy,
                       input logic [31:0] bd);
    core_req_i   = req;
    core_we_i    = we;
    core_addr_i  = a;
    core_data_i  = d;
    core_flush_i = fl;
    bus_ready_i  = rdy;
    bus_data_i   = bd;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy, 32'h0);
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 1'b0, 32'h0);
    mid();
    chk("store_nohold", core_hold_o, 32'h0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_a[3];
    logic [31:0] exp_d[3];
    int          hc;

    rst = 1'b0;
    idle(1'b0);
    mid();
    chk("reset_empty", empty_o, 32'h1);
    chk("reset_bus_req", bus_req_o, 32'h0);
    nxt();
    nxt();
    rst = 1'b1;

    // burst fill, 5th store stalls until a slot frees
    for (int i = 0; i < 4; i++) store(32'h1000_0000 + 32'(4 * i), 32'hA0 + 32'(i));
    drive(1'b1, 1'b1, 32'h1000_0010, 32'hA4, 1'b0, 1'b0, 32'h0);
    mid();
    chk("full_hold", core_hold_o, 32'h1);
    chk("full_head_addr", bus_addr_o, 32'h1000_0000);
    chk("full_head_data", bus_data_o, 32'hA0);
    nxt();
    drive(1'b1, 1'b1, 32'h1000_0010, 32'hA4, 1'b0, 1'b1, 32'h0);
    mid();
    chk("full_pop_still_hold", core_hold_o, 32'h1);
    chk("full_pop_addr", bus_addr_o, 32'h1000_0000);
    nxt();
    mid();
    chk("fifth_admitted", core_hold_o, 32'h0);
    chk("second_drain_addr", bus_addr_o, 32'h1000_0004);
    nxt();
    exp_a = '{32'h1000_0008, 32'h1000_000C, 32'h1000_0010};
    exp_d = '{32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      mid();
      chk("drain_order_addr", bus_addr_o, exp_a[i]);
      chk("drain_order_data", bus_data_o, exp_d[i]);
      nxt();
    end
    idle(1'b1);
    mid();
    chk("drained_empty", empty_o, 32'h1);
    nxt();

    // store-to-load forwarding with byte address
    store(32'h1000_0040, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h1000_0042, 32'h0, 1'b0, 1'b0, 32'hCAFE_0000);
    mid();
    chk("fwd_data", core_data_o, 32'hDEAD_BEEF);
    chk("fwd_nohold", core_hold_o, 32'h0);
    chk("fwd_no_read", bus_we_o, 32'h1);
    nxt();
    idle(1'b1);
    nxt();

    // youngest match forwarded
    store(32'h1000_0010, 32'h11);
    store(32'h1000_0010, 32'h22);
    drive(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 1'b0, 32'h0);
    mid();
    chk("fwd_youngest", core_data_o, 32'h22);
    nxt();
    idle(1'b1);
    nxt();
    nxt();

    // IO write ordered behind queued stores
    store(32'h1000_0020, 32'hB0);
    store(32'h1000_0024, 32'hB1);
    drive(1'b1, 1'b1, 32'h2000_0000, 32'h55, 1'b0, 1'b1, 32'h0);
    mid();
    chk("io_wait1_hold", core_hold_o, 32'h1);
    chk("io_wait1_addr", bus_addr_o, 32'h1000_0020);
    nxt();
    mid();
    chk("io_wait2_hold", core_hold_o, 32'h1);
    chk("io_wait2_addr", bus_addr_o, 32'h1000_0024);
    nxt();
    drive(1'b1, 1'b1, 32'h2000_0000, 32'h55, 1'b0, 1'b0, 32'h0);
    mid();
    chk("io_pass_hold", core_hold_o, 32'h1);
    chk("io_pass_addr", bus_addr_o, 32'h2000_0000);
    chk("io_pass_data", bus_data_o, 32'h55);
    nxt();
    bus_ready_i = 1'b1;
    mid();
    chk("io_done_hold", core_hold_o, 32'h0);
    nxt();
    idle(1'b0);
    nxt();

    // load miss takes priority over drain
    store(32'h1000_0030, 32'h77);
    drive(1'b1, 1'b0, 32'h1000_0100, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    mid();
    chk("miss_data", core_data_o, 32'h1234_5678);
    chk("miss_hold", core_hold_o, 32'h0);
    chk("miss_read", bus_we_o, 32'h0);
    chk("miss_addr", bus_addr_o, 32'h1000_0100);
    nxt();
    idle(1'b1);
    mid();
    chk("after_miss_drain", bus_addr_o, 32'h1000_0030);
    nxt();

    // fence holds exactly for the drain cycles
    store(32'h1000_0060, 32'hC0);
    store(32'h1000_0064, 32'hC1);
    store(32'h1000_0068, 32'hC2);
    hc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      mid();
      if (!core_hold_o) break;
      hc++;
      nxt();
    end
    chk("flush_hold_cycles", 32'(hc), 32'd3);
    chk("flush_empty", empty_o, 32'h1);
    nxt();

    // reset mid-drain discards the queue
    store(32'h1000_0050, 32'hD0);
    store(32'h1000_0054, 32'hD1);
    idle(1'b1);
    mid();
    chk("pre_rst_drain", bus_addr_o, 32'h1000_0050);
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_mid_req", bus_req_o, 32'h0);
    chk("rst_mid_empty", empty_o, 32'h1);
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("post_rst_no_write", bus_req_o, 32'h0);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
